cnn_frame_sequencer: RTL and testbench
======================================

Name: cnn_frame_sequencer

Overview:
Frame-level controller in front of the stage-3 classifier (max-pool → channel accumulate → core → alpha compare). It accepts one frame's worth of ReLU beats from the upstream stage only after a start command. It forwards exactly BEATS_PER_FRAME beats into stage 3, then waits for the classifier's result strobe. It latches the resulting ASCII letter, pulses done, and guards the wait with a watchdog so a lost result cannot hang the system.

Parameters:
DATA_W, 48, width of one ReLU beat; must equal stage-2 channel count × feature bit width.
BEATS_PER_FRAME, 16, ReLU beats per frame; legal range 2..65535.
TIMEOUT_CYCLES, 255, WAIT_RES cycles allowed before timeout error; legal range 1..65535.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i_start  in  1  start-frame request; sampled only in IDLE
i_abort  in  1  abort current frame; any state
i_src_valid  in  1  upstream beat valid
i_src_data  in  DATA_W  upstream ReLU beat
o_src_ready  out  1  sequencer accepts a beat this cycle
o_relu_valid  out  1  beat strobe to stage 3
o_relu_data  out  DATA_W  beat to stage 3
i_res_valid  in  1  stage-3 result strobe
i_res_alpha  in  8  stage-3 letter (0x61/0x62/0x63)
o_alpha  out  8  last captured letter
o_done  out  1  one-cycle frame-complete pulse
o_busy  out  1  high in FEED or WAIT_RES
o_err_timeout  out  1  sticky watchdog error
o_frame_cnt  out  8  completed-frame counter

Behaviour:
- Clock and reset:
  - Single clock clk.
  - reset_n is asynchronous and active-low.
  - All registers and outputs reset to 0; FSM resets to IDLE.
- States: IDLE, FEED, WAIT_RES.
- IDLE:
  - o_src_ready=0, o_busy=0.
  - i_start=1 && i_abort=0 → FEED next cycle.
  - On that transition: beat counter and watchdog counter cleared, o_err_timeout cleared.
- FEED:
  - o_src_ready=1 combinationally from state.
  - A beat is accepted when i_src_valid && o_src_ready.
  - Accepted beat appears on o_relu_valid/o_relu_data exactly 1 cycle later (registered).
  - o_relu_valid=0 on every cycle without an accepted beat; o_relu_data holds its last value.
  - Beat counter increments per accepted beat.
  - Acceptance while counter==BEATS_PER_FRAME-1 → WAIT_RES next cycle. Ready drops that next cycle; no extra beat is ever accepted.
- WAIT_RES:
  - Watchdog counts cycles from 0.
  - i_res_valid=1 → o_alpha<=i_res_alpha; o_done=1 for the following cycle; o_frame_cnt+1 (wraps 255→0); → IDLE.
  - Watchdog reaching TIMEOUT_CYCLES-1 without result → o_err_timeout<=1, → IDLE. No done pulse, o_alpha unchanged.
  - Result and timeout in the same cycle: the result wins.
- i_res_valid outside WAIT_RES: ignored; o_alpha, o_done, o_frame_cnt unchanged.
- i_start outside IDLE: ignored.
- i_abort=1 in any state:
  - → IDLE next cycle.
  - Counters cleared; o_relu_valid forced 0 that next cycle, even if a beat was accepted in the abort cycle.
  - No done pulse; o_err_timeout and o_frame_cnt unchanged.
  - Abort wins over start and over result.
- Latency: start → first possible ready = 1 cycle; last beat accepted → WAIT_RES = 1 cycle; result → o_done = 1 cycle.
- Async reset mid-frame: immediate return to IDLE with all outputs 0, including o_relu_valid.

Optional Feature:
CNN_FRAME_SEQ_TIMEOUT_EN
- Defined: watchdog logic as above; o_err_timeout functional.
- Undefined: watchdog counter not built; WAIT_RES waits indefinitely for i_res_valid or i_abort; o_err_timeout tied 0; TIMEOUT_CYCLES unused.

Test Plan:
- Nominal frame, BEATS_PER_FRAME=16, i_src_valid held 1:
  - i_start pulse → 16 consecutive o_relu_valid pulses matching input data, delayed 1 cycle.
  - Ready low after the 16th acceptance.
  - i_res_valid with alpha 0x62 → o_alpha=0x62, single o_done pulse, o_frame_cnt=1, o_busy=0.
- Bursty source, i_src_valid toggling 1/0:
  - Exactly 16 beats forwarded, no duplicates or drops.
  - o_relu_valid low on idle cycles.
- Timeout (macro defined), TIMEOUT_CYCLES=8, no result:
  - o_err_timeout=1 on the 8th WAIT_RES cycle, back to IDLE, o_done never pulses.
  - Next i_start clears the error.
- Simultaneous result and timeout in the same cycle:
  - o_done=1, o_alpha captured, o_err_timeout=0.
- Abort during FEED after 5 beats, with a beat accepted in the abort cycle:
  - o_relu_valid=0 next cycle, state IDLE, o_frame_cnt unchanged.
  - A spurious i_res_valid with 0x61 afterwards leaves o_alpha unchanged.
- Counter wrap and reset:
  - 256 completed frames → o_frame_cnt returns to 0.
  - reset_n low mid-FEED → all outputs 0 asynchronously.

Source files
------------

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: start-gated beat feeder and result catcher in front of the stage-3 classifier.
// Optional result watchdog is built only when CNN_FRAME_SEQ_TIMEOUT_EN is defined.
module cnn_frame_sequencer #(
  parameter int DATA_W          = 48,
  parameter int BEATS_PER_FRAME = 16,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_src_valid,
  input  logic [DATA_W-1:0] i_src_data,
  output logic              o_src_ready,
  output logic              o_relu_valid,
  output logic [DATA_W-1:0] o_relu_data,
  input  logic              i_res_valid,
  input  logic [7:0]        i_res_alpha,
  output logic [7:0]        o_alpha,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_err_timeout,
  output logic [7:0]        o_frame_cnt
);

  // state      | meaning
  // S_IDLE     | waiting for i_start
  // S_FEED     | forwarding BEATS_PER_FRAME beats into stage 3
  // S_WAIT_RES | frame sent, waiting for the classifier result strobe
  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT_RES} state_t;

  localparam logic [15:0] LAST_BEAT = 16'(BEATS_PER_FRAME - 1);

  state_t      state_q, state_d;
  logic [15:0] beat_cnt_q;
  logic        accept, fwd, res_take, timeout_hit;

  assign o_src_ready = (state_q == S_FEED);
  assign o_busy      = (state_q != S_IDLE);
  assign accept      = o_src_ready && i_src_valid;
  // a beat taken in the abort cycle is dropped, never forwarded
  assign fwd         = accept && !i_abort;

  always_comb begin
    state_d  = state_q;
    res_take = 1'b0;
    case (state_q)
      S_IDLE:     if (i_start) state_d = S_FEED;
      S_FEED:     if (accept && (beat_cnt_q == LAST_BEAT)) state_d = S_WAIT_RES;
      S_WAIT_RES: begin
        if (i_res_valid) begin
          res_take = 1'b1;
          state_d  = S_IDLE;
        end else if (timeout_hit) begin
          state_d  = S_IDLE;
        end
      end
      default:    state_d = S_IDLE;
    endcase
    if (i_abort) begin
      state_d  = S_IDLE;
      res_take = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          beat_cnt_q <= '0;
    else if (state_q != S_FEED || i_abort) beat_cnt_q <= '0;
    else if (accept)                       beat_cnt_q <= beat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_relu_valid <= 1'b0;
      o_relu_data  <= '0;
      o_done       <= 1'b0;
      o_alpha      <= '0;
      o_frame_cnt  <= '0;
    end else begin
      o_relu_valid <= fwd;
      o_done       <= res_take;
      if (fwd) o_relu_data <= i_src_data;
      if (res_take) begin
        o_alpha     <= i_res_alpha;
        o_frame_cnt <= o_frame_cnt + 8'd1;
      end
    end
  end

`ifdef CNN_FRAME_SEQ_TIMEOUT_EN
  localparam logic [15:0] WDOG_INIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog_q;
  logic        err_q;

  // down-counter reloads outside WAIT_RES; terminal count marks the last allowed cycle
  assign timeout_hit   = (state_q == S_WAIT_RES) && (wdog_q == 16'd0);
  assign o_err_timeout = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  wdog_q <= '0;
    else if (state_q != S_WAIT_RES) wdog_q <= WDOG_INIT;
    else if (wdog_q != 16'd0)       wdog_q <= wdog_q - 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                           err_q <= 1'b0;
    else if (state_q == S_IDLE && state_d == S_FEED)        err_q <= 1'b0;
    else if (timeout_hit && !i_res_valid && !i_abort)       err_q <= 1'b1;
  end
`else
  assign timeout_hit   = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: driver pushes expected beats/results, monitor pops on strobes.
// Timeout scenario depends on CNN_FRAME_SEQ_TIMEOUT_EN.
module tb_cnn_frame_sequencer;
  localparam int DATA_W = 48;
  localparam int BEATS  = 16;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_start, i_abort, i_src_valid, i_res_valid;
  logic [DATA_W-1:0] i_src_data;
  logic [7:0]        i_res_alpha;
  logic              o_src_ready, o_relu_valid, o_done, o_busy, o_err_timeout;
  logic [DATA_W-1:0] o_relu_data;
  logic [7:0]        o_alpha, o_frame_cnt;

  int compared = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] exp_beats[$];
  logic [7:0]        exp_res_alpha[$];
  logic [7:0]        exp_res_cnt[$];
  logic [7:0]        exp_frames = '0;
  logic [7:0]        exp_alpha = '0;
  logic [DATA_W-1:0] mon_beat;
  logic [7:0]        mon_a, mon_c;

  cnn_frame_sequencer #(.DATA_W(DATA_W), .BEATS_PER_FRAME(BEATS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_src_valid(i_src_valid), .i_src_data(i_src_data), .o_src_ready(o_src_ready),
    .o_relu_valid(o_relu_valid), .o_relu_data(o_relu_data),
    .i_res_valid(i_res_valid), .i_res_alpha(i_res_alpha), .o_alpha(o_alpha),
    .o_done(o_done), .o_busy(o_busy), .o_err_timeout(o_err_timeout), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every strobe must match the head of its queue
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (o_relu_valid) begin
        if (exp_beats.size() == 0) chk("relu_unexpected_beat", 64'(o_relu_valid), 64'd0);
        else begin
          mon_beat = exp_beats.pop_front();
          chk("relu_data", 64'(o_relu_data), 64'(mon_beat));
        end
      end
      if (o_done) begin
        if (exp_res_alpha.size() == 0) chk("done_unexpected", 64'(o_done), 64'd0);
        else begin
          mon_a = exp_res_alpha.pop_front();
          mon_c = exp_res_cnt.pop_front();
          chk("done_alpha", 64'(o_alpha), 64'(mon_a));
          chk("done_frame_cnt", 64'(o_frame_cnt), 64'(mon_c));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

  task automatic start_frame();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'd1);
  endtask

  task automatic feed(input int nb, input bit bursty, input logic [15:0] tag);
    int n = 0;
    int cyc = 0;
    while (n < nb && cyc < 200) begin
      i_src_valid = bursty ? ~cyc[0] : 1'b1;
      i_src_data  = {16'hbeef, tag, 16'(n)};
      chk("src_ready_feed", 64'(o_src_ready), 64'd1);
      if (i_src_valid) begin
        exp_beats.push_back(i_src_data);
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    if (n < nb) chk("feed_cycle_budget", 64'(n), 64'(nb));
  endtask

  // full frame ends one cycle into WAIT_RES with a rejected extra beat offered
  task automatic full_frame(input bit bursty, input logic [15:0] tag);
    start_frame();
    feed(BEATS, bursty, tag);
    i_src_valid = 1'b1;
    i_src_data  = {16'hdead, tag, 16'hffff};
    chk("src_ready_after_last", 64'(o_src_ready), 64'd0);
    chk("busy_wait_res", 64'(o_busy), 64'd1);
    @(negedge clk);
    i_src_valid = 1'b0;
  endtask

  task automatic send_result(input logic [7:0] a);
    i_res_valid = 1'b1;
    i_res_alpha = a;
    exp_frames  = exp_frames + 8'd1;
    exp_alpha   = a;
    exp_res_alpha.push_back(a);
    exp_res_cnt.push_back(exp_frames);
    @(negedge clk);
    i_res_valid = 1'b0;
    chk("busy_after_result", 64'(o_busy), 64'd0);
    chk("alpha_after_result", 64'(o_alpha), 64'(a));
    chk("frame_cnt_after_result", 64'(o_frame_cnt), 64'(exp_frames));
    chk("err_after_result", 64'(o_err_timeout), 64'd0);
  endtask

  initial begin
    int guard;
    reset_n = 1'b0; i_start = 0; i_abort = 0; i_src_valid = 0; i_res_valid = 0;
    i_src_data = '0; i_res_alpha = '0;
    repeat (2) @(negedge clk);
    chk("rst_src_ready", 64'(o_src_ready), 64'd0);
    chk("rst_relu_valid", 64'(o_relu_valid), 64'd0);
    chk("rst_relu_data", 64'(o_relu_data), 64'd0);
    chk("rst_alpha", 64'(o_alpha), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_err", 64'(o_err_timeout), 64'd0);
    chk("rst_frame_cnt", 64'(o_frame_cnt), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready_low", 64'(o_src_ready), 64'd0);

    // nominal, continuous source
    full_frame(1'b0, 16'h0001);
    send_result(8'h62);
    @(negedge clk);

    // bursty source
    full_frame(1'b1, 16'h0002);
    send_result(8'h63);
    @(negedge clk);

    // result arrives on the last watchdog cycle: result wins
    full_frame(1'b0, 16'h0003);
    repeat (TMO - 2) begin
      chk("err_before_last_cycle", 64'(o_err_timeout), 64'd0);
      @(negedge clk);
    end
    send_result(8'h61);
    @(negedge clk);

    // no result
    full_frame(1'b0, 16'h0004);
`ifdef CNN_FRAME_SEQ_TIMEOUT_EN
    repeat (TMO - 1) begin
      chk("tmo_busy_waiting", 64'(o_busy), 64'd1);
      chk("tmo_err_low", 64'(o_err_timeout), 64'd0);
      @(negedge clk);
    end
    chk("tmo_err_set", 64'(o_err_timeout), 64'd1);
    chk("tmo_idle", 64'(o_busy), 64'd0);
    chk("tmo_alpha_kept", 64'(o_alpha), 64'(exp_alpha));
    chk("tmo_frame_cnt_kept", 64'(o_frame_cnt), 64'(exp_frames));
    @(negedge clk);
`else
    repeat (3 * TMO) begin
      chk("nowdog_busy_waiting", 64'(o_busy), 64'd1);
      chk("nowdog_err_low", 64'(o_err_timeout), 64'd0);
      @(negedge clk);
    end
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("nowdog_abort_idle", 64'(o_busy), 64'd0);
`endif

    // next start clears error; abort after 5 beats with a beat taken in the abort cycle
    start_frame();
    chk("err_cleared_by_start", 64'(o_err_timeout), 64'd0);
    feed(5, 1'b0, 16'h0005);
    i_src_valid = 1'b1;
    i_src_data  = 48'h0bad_0bad_0bad;
    i_abort     = 1'b1;
    chk("ready_in_abort_cycle", 64'(o_src_ready), 64'd1);
    @(negedge clk);
    i_abort = 1'b0; i_src_valid = 1'b0;
    chk("abort_relu_valid", 64'(o_relu_valid), 64'd0);
    chk("abort_idle", 64'(o_busy), 64'd0);
    chk("abort_ready_low", 64'(o_src_ready), 64'd0);
    chk("abort_frame_cnt", 64'(o_frame_cnt), 64'(exp_frames));
    @(negedge clk);
    i_res_valid = 1'b1; i_res_alpha = 8'h61;
    if (exp_alpha == 8'h61) i_res_alpha = 8'h62;
    @(negedge clk);
    i_res_valid = 1'b0;
    @(negedge clk);
    chk("spurious_res_alpha", 64'(o_alpha), 64'(exp_alpha));
    chk("spurious_res_cnt", 64'(o_frame_cnt), 64'(exp_frames));

    // run frames until the counter wraps 255 -> 0
    guard = 0;
    do begin
      full_frame(1'b0, 16'(guard + 16'h100));
      send_result(8'h61 + 8'(guard % 3));
      guard++;
    end while (exp_frames != 8'd0 && guard < 300);
    chk("wrap_frame_cnt", 64'(o_frame_cnt), 64'd0);
    @(negedge clk);

    // async reset mid-FEED while a beat is on the output
    start_frame();
    feed(3, 1'b0, 16'h0777);
    i_src_valid = 1'b0;
    chk("pre_reset_relu_valid", 64'(o_relu_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_src_ready", 64'(o_src_ready), 64'd0);
    chk("arst_relu_valid", 64'(o_relu_valid), 64'd0);
    chk("arst_relu_data", 64'(o_relu_data), 64'd0);
    chk("arst_alpha", 64'(o_alpha), 64'd0);
    chk("arst_done", 64'(o_done), 64'd0);
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_err", 64'(o_err_timeout), 64'd0);
    chk("arst_frame_cnt", 64'(o_frame_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_frames = '0; exp_alpha = '0;
    repeat (2) @(negedge clk);

    chk("beats_left_in_queue", 64'(exp_beats.size()), 64'd0);
    chk("results_left_in_queue", 64'(exp_res_alpha.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
